// File: rtl/hpdmc_dq_pkg.sv
// rtl/hpdmc_dq_pkg.sv - shared types and constants for the DDR DQ bus controller
package hpdmc_dq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_WR_POST,
        ST_RD_WAIT,
        ST_RD_BURST
    } dq_state_t;

    localparam int DQ_MAX = 32;
    localparam logic [DQ_MAX-1:0] DQ_HIZ = '1;

    // Width of a counter that must hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hpdmc_dq_capture.sv
// rtl/hpdmc_dq_capture.sv - read-latency timer, DQ sample register and rd_valid generation
module hpdmc_dq_capture
    import hpdmc_dq_pkg::*;
#(
    parameter int DDRBITS = 32,
    parameter int CL      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               waiting,
    input  logic               burst,
    input  logic [DDRBITS-1:0] dq_i,
    output logic               wait_done,
    output logic [DDRBITS-1:0] rd_data,
    output logic               rd_valid
);

    localparam int WAIT_W = cnt_width(CL);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CL - 1);

    logic [WAIT_W-1:0] wait_cnt;

    // wait_cnt equals the cycle index since accept while in RD_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= WAIT_W'(1);
        end else if (waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign wait_done = waiting && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= burst;
            if (burst) begin
                rd_data <= dq_i;
            end
        end
    end

endmodule

// File: rtl/hpdmc_dq_ctl.sv
// rtl/hpdmc_dq_ctl.sv - DDR DQ bus owner: write serialiser, read capture, read->write turnaround
module hpdmc_dq_ctl
    import hpdmc_dq_pkg::*;
#(
    parameter int DDRBITS = 32,
    parameter int BURST   = 4,
    parameter int CL      = 3,
    parameter int TURN    = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               cmd_valid,
    input  logic               cmd_write,
    output logic               cmd_ready,
    input  logic [DDRBITS-1:0] wr_data,
    output logic               wr_ack,
    output logic [DDRBITS-1:0] rd_data,
    output logic               rd_valid,
    output logic [DDRBITS-1:0] dq_t,
    output logic [DDRBITS-1:0] dq_o,
    input  logic [DDRBITS-1:0] dq_i
);

    localparam int BEAT_W = cnt_width(BURST);
    localparam int TURN_W = cnt_width(TURN);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BURST - 1);
    localparam logic [TURN_W-1:0]  TURN_LOAD = TURN_W'(TURN);
    localparam logic [DDRBITS-1:0] HIZ       = DQ_HIZ[DDRBITS-1:0];

    dq_state_t state, next_state;

    logic [BEAT_W-1:0]  beat_cnt;
    logic [TURN_W-1:0]  turn_cnt;
    logic [DDRBITS-1:0] dq_t_r;
    logic [DDRBITS-1:0] dq_o_r;
    logic               accept;
    logic               in_burst;
    logic               last_beat;
    logic               wait_done;

    assign cmd_ready = (state == ST_IDLE) && !(cmd_write && (turn_cnt != '0));
    assign accept    = cmd_valid && cmd_ready;
    assign in_burst  = (state == ST_WR_BURST) || (state == ST_RD_BURST);
    assign last_beat = in_burst && (beat_cnt == LAST_BEAT);
    assign wr_ack    = (state == ST_WR_BURST);
    assign dq_t      = dq_t_r;
    assign dq_o      = dq_o_r;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_write) begin
                        next_state = ST_WR_BURST;
                    end else if (CL == 1) begin
                        next_state = ST_RD_BURST;
                    end else begin
                        next_state = ST_RD_WAIT;
                    end
                end
            end
            ST_WR_BURST: if (last_beat) next_state = ST_WR_POST;
            ST_WR_POST:  next_state = ST_IDLE;
            ST_RD_WAIT:  if (wait_done) next_state = ST_RD_BURST;
            ST_RD_BURST: if (last_beat) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // beat_cnt is zero on entry to either burst state and counts beats already done.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt <= '0;
        end else if (in_burst && !last_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end else begin
            beat_cnt <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            turn_cnt <= '0;
        end else if ((state == ST_RD_BURST) && last_beat) begin
            turn_cnt <= TURN_LOAD;
        end else if (turn_cnt != '0) begin
            turn_cnt <= turn_cnt - 1'b1;
        end
    end

    // Output registers sit next to the IOBs; the bus is released on the edge leaving WR_POST.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dq_t_r <= HIZ;
            dq_o_r <= '0;
        end else if (state == ST_WR_BURST) begin
            dq_t_r <= '0;
            dq_o_r <= wr_data;
        end else if (state == ST_WR_POST) begin
            dq_t_r <= HIZ;
        end
    end

    hpdmc_dq_capture #(
        .DDRBITS (DDRBITS),
        .CL      (CL)
    ) u_capture (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .start     (accept && !cmd_write),
        .waiting   (state == ST_RD_WAIT),
        .burst     (state == ST_RD_BURST),
        .dq_i      (dq_i),
        .wait_done (wait_done),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

endmodule

// File: tb/tb_hpdmc_dq_ctl.sv
// tb/tb_hpdmc_dq_ctl.sv - scoreboard bench for hpdmc_dq_ctl
module tb_hpdmc_dq_ctl;

    localparam int DDRBITS = 32;
    localparam int BURST   = 4;
    localparam int CL      = 3;
    localparam int TURN    = 2;

    logic               sys_clk   = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_write = 1'b0;
    logic [DDRBITS-1:0] wr_data   = '0;
    logic [DDRBITS-1:0] dq_i      = '0;
    logic               cmd_ready;
    logic               wr_ack;
    logic [DDRBITS-1:0] rd_data;
    logic               rd_valid;
    logic [DDRBITS-1:0] dq_t;
    logic [DDRBITS-1:0] dq_o;

    hpdmc_dq_ctl #(
        .DDRBITS (DDRBITS),
        .BURST   (BURST),
        .CL      (CL),
        .TURN    (TURN)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_write (cmd_write),
        .cmd_ready (cmd_ready),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .dq_t      (dq_t),
        .dq_o      (dq_o),
        .dq_i      (dq_i)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t         dq_q[$];
    ev_t         rd_q[$];
    ev_t         di_q[$];
    int          wack_q[$];
    logic [31:0] wq[$];

    int total  = 0;
    int bad    = 0;
    int rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flush();
        dq_q.delete();
        rd_q.delete();
        di_q.delete();
        wack_q.delete();
        wq.delete();
    endtask

    // Monitor: every DUT output event must match the head of its expectation queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (wr_ack) begin
                    if (wack_q.size() == 0) chk("wr_ack_spurious", {31'b0, wr_ack}, 32'd0);
                    else chk("wr_ack_cycle", cyc, wack_q.pop_front());
                end
                if (dq_t !== '1) begin
                    if (dq_q.size() == 0) begin
                        chk("dq_t_spurious", dq_t, 32'hFFFF_FFFF);
                    end else begin
                        e = dq_q.pop_front();
                        chk("dq_drive_cycle", cyc, e.cyc);
                        chk("dq_t_drive", dq_t, 32'h0);
                        chk("dq_o", dq_o, e.data);
                    end
                end
                if (rd_valid) begin
                    rd_cnt++;
                    if (rd_q.size() == 0) begin
                        chk("rd_valid_spurious", {31'b0, rd_valid}, 32'd0);
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_valid_cycle", cyc, e.cyc);
                        chk("rd_data", rd_data, e.data);
                    end
                end
            end
        end
    end

    // Write-data feeder: presents the next queued beat, junk when nothing is owed.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (wr_ack && wq.size() != 0) void'(wq.pop_front());
            @(posedge sys_clk);
            #1;
            wr_data = (wq.size() != 0) ? wq[0] : $urandom;
        end
    end

    // DQ input feeder: read beats appear only in their scheduled cycles.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (di_q.size() != 0 && di_q[0].cyc == cyc) dq_i = di_q.pop_front().data;
            else dq_i = $urandom;
        end
    end

    task automatic issue(input bit wr, input logic [127:0] beats, output int acc);
        acc = -1;
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        for (int n = 0; n < 60; n++) begin
            @(negedge sys_clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("accept_timeout", {31'b0, cmd_ready}, 32'd1);
        end else begin
            for (int k = 0; k < BURST; k++) begin
                if (wr) begin
                    wack_q.push_back(acc + 1 + k);
                    dq_q.push_back('{acc + 2 + k, beats[32*k +: 32]});
                    wq.push_back(beats[32*k +: 32]);
                end else begin
                    di_q.push_back('{acc + CL + k, beats[32*k +: 32]});
                    rd_q.push_back('{acc + CL + 1 + k, beats[32*k +: 32]});
                end
            end
        end
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int n = 0; n < 60; n++) begin
            @(negedge sys_clk);
            left = dq_q.size() + rd_q.size() + wack_q.size();
            if (left == 0) break;
        end
        chk("drain_pending", left, 32'd0);
        repeat (3) @(negedge sys_clk);
    endtask

    int a0, a1, rd_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

    initial begin
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_dq_t", dq_t, 32'hFFFF_FFFF);
        chk("rst_dq_o", dq_o, 32'h0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rd_data", rd_data, 32'h0);

        // Plain write burst.
        issue(1'b1, 128'h44444444_33333333_22222222_11111111, a0);
        drain();

        // Plain read burst.
        issue(1'b0, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, a0);
        drain();

        // Read followed by a write held asserted: turnaround gap.
        issue(1'b0, 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0, a0);
        issue(1'b1, 128'h58585858_57575757_56565656_55555555, a1);
        chk("turn_accept_gap", a1 - a0, CL + BURST + TURN);
        drain();

        // Back-to-back reads.
        rd_before = rd_cnt;
        issue(1'b0, 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0, a0);
        issue(1'b0, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, a1);
        chk("rr_accept_gap", a1 - a0, CL + BURST);
        drain();
        chk("rr_pulses", rd_cnt - rd_before, 2 * BURST);

        // Write followed by read.
        issue(1'b1, 128'h0F0F0F0F_F0F0F0F0_00FF00FF_12345678, a0);
        issue(1'b0, 128'h9ABCDEF0_87654321_CAFEF00D_DEADBEEF, a1);
        chk("wr_accept_gap", a1 - a0, BURST + 2);
        drain();

        // Reset in the middle of a write burst.
        issue(1'b1, 128'h77777777_66666666_65656565_64646464, a0);
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        flush();
        #1;
        chk("mid_rst_dq_t", dq_t, 32'hFFFF_FFFF);
        chk("mid_rst_dq_o", dq_o, 32'h0);
        chk("mid_rst_wr_ack", {31'b0, wr_ack}, 32'd0);
        chk("mid_rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("mid_rst_rd_data", rd_data, 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("post_rst_dq_t", dq_t, 32'hFFFF_FFFF);
        repeat (8) @(negedge sys_clk);

        // Recovery after reset.
        issue(1'b0, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, a0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
